dmem_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the MEM-stage load/store interface.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 memory-interface types plus the lane helpers used by the
// data-memory responder.
package riscv_pkg;

    typedef enum logic [1:0] {
        SIZE_B    = 2'b00,
        SIZE_H    = 2'b01,
        SIZE_W    = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } dmem_state_t;

    function automatic logic [3:0] byte_enables(mem_size_t size, logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << lane;
            SIZE_H:  be = 4'b0011 << {lane[1], 1'b0};
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Picks the addressed lane out of a RAM word and widens it to 32 bits.
    function automatic logic [31:0] extend_load(logic [31:0] word, mem_size_t size,
                                                logic [1:0] lane, logic is_unsigned);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            SIZE_B:  result = is_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  result = is_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i && be_i[i]) begin
                mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_q <= mem[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the MEM-stage load/store handshake: accepts one request,
// stalls WAIT_CYCLES, performs the RAM access and holds the response until taken.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RANGE_BYTES = 33'(4 * longint'(DEPTH_WORDS));

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    mem_size_t   size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic             access;
    logic             misaligned;
    logic             acc_err;
    logic [31:0]      access_off;
    logic [31:0]      sel_addr;
    logic [31:0]      ram_off;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;
    logic             ram_we;

    // The RAM read is registered, so while idle it already looks up the
    // incoming address; that keeps a zero-wait load at one cycle of latency.
    assign sel_addr   = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign ram_off    = sel_addr - BASE_ADDR;
    assign access_off = addr_q - BASE_ADDR;

    always_comb begin
        case (size_q)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = addr_q[0];
            SIZE_W:  misaligned = |addr_q[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign acc_err = misaligned || ({1'b0, access_off} >= RANGE_BYTES);

    always_comb begin
        case (size_q)
            SIZE_B:  ram_wdata = {4{wdata_q[7:0]}};
            SIZE_H:  ram_wdata = {2{wdata_q[15:0]}};
            default: ram_wdata = wdata_q;
        endcase
    end

    assign ram_we = access && write_q && !acc_err && !rst;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i  (clk),
        .we_i   (ram_we),
        .be_i   (byte_enables(size_q, addr_q[1:0])),
        .idx_i  (ram_off[IDX_W+1:2]),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        access     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = mem_size_t'(req_size);
                    unsigned_d = req_unsigned;
                    cnt_d      = 4'(WAIT_CYCLES);
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    err_d   = acc_err;
                    rdata_d = (write_q || acc_err) ? 32'h0
                            : extend_load(ram_rdata, size_q, addr_q[1:0], unsigned_q);
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (wait 1, wait 3, wait 0 with a high base)
// checked against a byte-addressed reference memory.
module tb_dmem_responder;

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] expRdata;
        bit          expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst        [3];
    logic        reqValid   [3];
    logic        reqReady   [3];
    logic        reqWrite   [3];
    logic [31:0] reqAddr    [3];
    logic [31:0] reqWdata   [3];
    logic [1:0]  reqSize    [3];
    logic        reqUnsigned[3];
    logic        respValid  [3];
    logic        respReady  [3];
    logic [31:0] respRdata  [3];
    logic        respErr    [3];

    int checkCount = 0;
    int passCount  = 0;
    logic [7:0] memModel [longint];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_write(reqWrite[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .req_size(reqSize[0]), .req_unsigned(reqUnsigned[0]), .resp_valid(respValid[0]),
        .resp_ready(respReady[0]), .resp_rdata(respRdata[0]), .resp_err(respErr[0]));

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0000)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_write(reqWrite[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .req_size(reqSize[1]), .req_unsigned(reqUnsigned[1]), .resp_valid(respValid[1]),
        .resp_ready(respReady[1]), .resp_rdata(respRdata[1]), .resp_err(respErr[1]));

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h8000_0000)) dut2 (
        .clk(clk), .rst(rst[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
        .req_write(reqWrite[2]), .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]),
        .req_size(reqSize[2]), .req_unsigned(reqUnsigned[2]), .resp_valid(respValid[2]),
        .resp_ready(respReady[2]), .resp_rdata(respRdata[2]), .resp_err(respErr[2]));

    function automatic int waitOf(int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction

    function automatic int depthOf(int d);
        return (d == 0) ? 1024 : (d == 1) ? 64 : 256;
    endfunction

    function automatic logic [31:0] baseOf(int d);
        return (d == 2) ? 32'h8000_0000 : 32'h0000_0000;
    endfunction

    function automatic longint keyOf(int d, logic [31:0] a);
        return (longint'(d) << 32) | longint'(a);
    endfunction

    // Reference behaviour: a flat byte memory, little-endian assembly of the accessed bytes.
    task automatic modelTxn(input int d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                            output logic [31:0] expRdata, output bit expErr);
        longint off;
        int     nBytes;
        longint val;
        off      = longint'(addr - baseOf(d));
        nBytes   = 1 << size;
        expErr   = (size == 2'b11) || ((addr % nBytes) != 0) || (off >= 4 * longint'(depthOf(d)));
        expRdata = 32'h0;
        if (!expErr && wr) begin
            for (int i = 0; i < nBytes; i++) memModel[keyOf(d, addr + i)] = wdata[8*i +: 8];
        end else if (!expErr) begin
            val = 0;
            for (int i = 0; i < nBytes; i++) val = val | (longint'(memModel[keyOf(d, addr + i)]) << (8 * i));
            if (!uns && nBytes < 4 && val[8*nBytes-1]) val = val - (longint'(1) << (8 * nBytes));
            expRdata = val[31:0];
        end
    endtask

    task automatic doTxn(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                         output logic [31:0] rdata, output bit err, output int lat);
        int w;
        @(negedge clk);
        reqWrite[d] = wr; reqAddr[d] = addr; reqWdata[d] = wdata;
        reqSize[d] = size; reqUnsigned[d] = uns; reqValid[d] = 1'b1;
        w = 0;
        while (reqReady[d] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        reqValid[d] = 1'b0;
        reqWrite[d] = 1'($urandom); reqAddr[d] = $urandom; reqWdata[d] = $urandom;
        reqSize[d] = 2'($urandom); reqUnsigned[d] = 1'($urandom);
        lat = 0;
        while (respValid[d] !== 1'b1 && lat <= 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (w >= 20 || lat > 40) lat = -1;
        rdata = respRdata[d];
        err   = respErr[d];
        @(negedge clk);
        respReady[d] = 1'b1;
        @(posedge clk);
        #1;
        respReady[d] = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkCount++;
            if ({reqReady[d], respValid[d], respErr[d], respRdata[d]} !== 35'h0) begin
                $display("[TB] FAIL reset_outputs dut%0d: ready=%b valid=%b err=%b rdata=%h, required all zero",
                         d, reqReady[d], respValid[d], respErr[d], respRdata[d]);
            end else passCount++;
            rst[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkCount++;
            if ({reqReady[d], respValid[d]} !== 2'b10) begin
                $display("[TB] FAIL reset_release dut%0d: ready=%b valid=%b, required ready=1 valid=0",
                         d, reqReady[d], respValid[d]);
            end else passCount++;
        end
    endtask

    task automatic test_lane_access();
        vec_t        vecs[12];
        logic [31:0] rdata, mRdata;
        bit          err, mErr;
        int          lat;
        vecs = '{
            '{0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h00000000, 0},
            '{0, 0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0},
            '{0, 1, 32'h10, 32'h80FF7F01, 2'b10, 0, 32'h00000000, 0},
            '{0, 0, 32'h13, 32'h0,        2'b00, 0, 32'hFFFFFF80, 0},
            '{0, 0, 32'h13, 32'h0,        2'b00, 1, 32'h00000080, 0},
            '{0, 0, 32'h10, 32'h0,        2'b01, 0, 32'h00007F01, 0},
            '{0, 0, 32'h12, 32'h0,        2'b01, 0, 32'hFFFF80FF, 0},
            '{0, 0, 32'h12, 32'h0,        2'b01, 1, 32'h000080FF, 0},
            '{0, 0, 32'h10, 32'h0,        2'b10, 1, 32'h80FF7F01, 0},
            '{0, 1, 32'h10, 32'h11223344, 2'b10, 0, 32'h00000000, 0},
            '{0, 1, 32'h11, 32'h000000AA, 2'b00, 0, 32'h00000000, 0},
            '{0, 0, 32'h10, 32'h0,        2'b10, 0, 32'h1122AA44, 0}
        };
        foreach (vecs[i]) begin
            modelTxn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                     vecs[i].uns, mRdata, mErr);
            doTxn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                  vecs[i].uns, rdata, err, lat);
            checkCount++;
            if (rdata !== vecs[i].expRdata || err !== vecs[i].expErr || lat != waitOf(vecs[i].d) + 1) begin
                $display("[TB] FAIL lane_access #%0d addr=%h: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         i, vecs[i].addr, rdata, err, lat, vecs[i].expRdata, vecs[i].expErr, waitOf(vecs[i].d) + 1);
            end else passCount++;
        end
    endtask

    task automatic test_errors();
        vec_t        vecs[11];
        logic [31:0] rdata, mRdata;
        bit          err, mErr;
        int          lat;
        vecs = '{
            '{0, 1, 32'h14,       32'h55667788, 2'b10, 0, 32'h00000000, 0},
            '{0, 0, 32'h12,       32'h0,        2'b10, 0, 32'h00000000, 1},
            '{0, 1, 32'h15,       32'h0000BBCC, 2'b01, 0, 32'h00000000, 1},
            '{0, 0, 32'h14,       32'h0,        2'b10, 0, 32'h55667788, 0},
            '{0, 0, 32'h1000,     32'h0,        2'b10, 0, 32'h00000000, 1},
            '{0, 1, 32'hFFC,      32'h0BADCAFE, 2'b10, 0, 32'h00000000, 0},
            '{0, 0, 32'hFFC,      32'h0,        2'b10, 0, 32'h0BADCAFE, 0},
            '{0, 0, 32'h14,       32'h0,        2'b11, 0, 32'h00000000, 1},
            '{2, 0, 32'h10,       32'h0,        2'b10, 0, 32'h00000000, 1},
            '{2, 1, 32'h80000000, 32'hA5A5A5A5, 2'b10, 0, 32'h00000000, 0},
            '{2, 0, 32'h80000400, 32'h0,        2'b10, 0, 32'h00000000, 1}
        };
        foreach (vecs[i]) begin
            modelTxn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                     vecs[i].uns, mRdata, mErr);
            doTxn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                  vecs[i].uns, rdata, err, lat);
            checkCount++;
            if (rdata !== vecs[i].expRdata || err !== vecs[i].expErr || lat != waitOf(vecs[i].d) + 1) begin
                $display("[TB] FAIL errors #%0d dut%0d addr=%h: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         i, vecs[i].d, vecs[i].addr, rdata, err, lat, vecs[i].expRdata, vecs[i].expErr,
                         waitOf(vecs[i].d) + 1);
            end else passCount++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rdata, mRdata;
        bit          err, mErr;
        int          lat;
        modelTxn(0, 1, 32'h30, 32'hCAFEF00D, 2'b10, 0, mRdata, mErr);
        doTxn(0, 1, 32'h30, 32'hCAFEF00D, 2'b10, 0, rdata, err, lat);
        modelTxn(0, 0, 32'h30, 32'h0, 2'b10, 0, mRdata, mErr);
        @(negedge clk);
        reqWrite[0] = 1'b0; reqAddr[0] = 32'h30; reqSize[0] = 2'b10; reqUnsigned[0] = 1'b0;
        reqValid[0] = 1'b1;
        @(posedge clk);
        #1;
        reqWrite[0] = 1'b1; reqAddr[0] = 32'h34; reqWdata[0] = 32'hFFFFFFFF;
        lat = 0;
        while (respValid[0] !== 1'b1 && lat <= 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkCount++;
            if (respValid[0] !== 1'b1 || respRdata[0] !== mRdata || respErr[0] !== 1'b0 || reqReady[0] !== 1'b0) begin
                $display("[TB] FAIL backpressure_hold cycle %0d: valid=%b rdata=%h err=%b ready=%b, required valid=1 rdata=%h err=0 ready=0",
                         c, respValid[0], respRdata[0], respErr[0], reqReady[0], mRdata);
            end else passCount++;
        end
        respReady[0] = 1'b1;
        reqValid[0]  = 1'b0;
        @(posedge clk);
        #1;
        respReady[0] = 1'b0;
        checkCount++;
        if (respValid[0] !== 1'b0 || reqReady[0] !== 1'b1) begin
            $display("[TB] FAIL backpressure_release: valid=%b ready=%b, required valid=0 ready=1",
                     respValid[0], reqReady[0]);
        end else passCount++;
        modelTxn(0, 0, 32'h34, 32'h0, 2'b10, 0, mRdata, mErr);
        doTxn(0, 0, 32'h34, 32'h0, 2'b10, 0, rdata, err, lat);
        checkCount++;
        if (err !== 1'b0 || lat != 2) begin
            $display("[TB] FAIL backpressure_followup: err=%b lat=%0d, required err=0 lat=2", err, lat);
        end else passCount++;
    endtask

    task automatic test_reset_midop();
        logic [31:0] rdata, mRdata;
        bit          err, mErr;
        int          lat;
        bit          sawResp;
        modelTxn(1, 1, 32'h20, 32'h0, 2'b10, 0, mRdata, mErr);
        doTxn(1, 1, 32'h20, 32'h0, 2'b10, 0, rdata, err, lat);
        checkCount++;
        if (err !== 1'b0 || lat != 4) begin
            $display("[TB] FAIL midop_setup: err=%b lat=%0d, required err=0 lat=4", err, lat);
        end else passCount++;
        @(negedge clk);
        reqWrite[1] = 1'b1; reqAddr[1] = 32'h20; reqWdata[1] = 32'h12345678;
        reqSize[1] = 2'b10; reqUnsigned[1] = 1'b0; reqValid[1] = 1'b1;
        @(posedge clk);
        #1;
        reqValid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        checkCount++;
        if (reqReady[1] !== 1'b0) begin
            $display("[TB] FAIL midop_ready_in_reset: ready=%b, required 0", reqReady[1]);
        end else passCount++;
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        checkCount++;
        if (reqReady[1] !== 1'b1) begin
            $display("[TB] FAIL midop_ready_after_reset: ready=%b, required 1", reqReady[1]);
        end else passCount++;
        sawResp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (respValid[1] !== 1'b0) sawResp = 1'b1;
        end
        checkCount++;
        if (sawResp) begin
            $display("[TB] FAIL midop_no_response: resp_valid rose after reset, required it to stay 0");
        end else passCount++;
        modelTxn(1, 0, 32'h20, 32'h0, 2'b10, 0, mRdata, mErr);
        doTxn(1, 0, 32'h20, 32'h0, 2'b10, 0, rdata, err, lat);
        checkCount++;
        if (rdata !== mRdata || rdata !== 32'h0 || err !== 1'b0 || lat != 4) begin
            $display("[TB] FAIL midop_readback: rdata=%h err=%b lat=%0d, required rdata=00000000 err=0 lat=4",
                     rdata, err, lat);
        end else passCount++;
    endtask

    task automatic test_random_traffic();
        logic [31:0] rdata, mRdata, addr, wdata, base;
        logic [1:0]  size;
        bit          err, mErr, wr, uns;
        int          lat, r;
        for (int d = 0; d < 3; d++) begin
            base = baseOf(d);
            for (int w = 0; w < 8; w++) begin
                wdata = $urandom;
                modelTxn(d, 1, base + 32'h40 + 32'(4 * w), wdata, 2'b10, 0, mRdata, mErr);
                doTxn(d, 1, base + 32'h40 + 32'(4 * w), wdata, 2'b10, 0, rdata, err, lat);
            end
            for (int n = 0; n < 30; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      addr = base + 32'(4 * depthOf(d)) + 32'($urandom_range(0, 7));
                else if (r == 1) addr = base - 32'($urandom_range(1, 8));
                else             addr = base + 32'h40 + 32'($urandom_range(0, 31));
                r    = $urandom_range(0, 7);
                size = (r == 7) ? 2'b11 : 2'(r % 3);
                wr   = 1'($urandom);
                uns  = 1'($urandom);
                wdata = $urandom;
                modelTxn(d, wr, addr, wdata, size, uns, mRdata, mErr);
                doTxn(d, wr, addr, wdata, size, uns, rdata, err, lat);
                checkCount++;
                if (rdata !== mRdata || err !== mErr || lat != waitOf(d) + 1) begin
                    $display("[TB] FAIL random dut%0d #%0d wr=%b addr=%h size=%0d uns=%b: got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                             d, n, wr, addr, size, uns, rdata, err, lat, mRdata, mErr, waitOf(d) + 1);
                end else passCount++;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; reqValid[d] = 1'b0; reqWrite[d] = 1'b0; reqAddr[d] = 32'h0;
            reqWdata[d] = 32'h0; reqSize[d] = 2'b00; reqUnsigned[d] = 1'b0; respReady[d] = 1'b0;
        end
        test_reset();
        test_lane_access();
        test_errors();
        test_backpressure();
        test_reset_midop();
        test_random_traffic();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
